// File: rtl/latch_input_conditioner.sv
// latch_input_conditioner
//   Cleans the raw board inputs feeding the D-latch / LED-mux lab block.
//   Every input channel (8 data switches, enable button, select switch) gets a
//   2-flop synchroniser followed by a 4-state debounce FSM. The enable channel
//   additionally produces registered one-cycle rise/fall pulses. A free-running
//   divider provides a slow square wave and a one-cycle tick on its rising edge.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   sw_raw     in   [7:0] raw data switches
//   en_raw     in   raw enable button
//   sel_raw    in   raw select switch
//   D          out  [7:0] debounced data switches
//   En         out  debounced enable
//   sel        out  debounced select
//   en_rise    out  one-cycle pulse, cycle after En goes 0->1
//   en_fall    out  one-cycle pulse, cycle after En goes 1->0
//   clk_alert  out  divider bit ALERT_BIT
//   alert_tick out  one-cycle pulse on each 0->1 transition of clk_alert
module latch_input_conditioner #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 26,
  parameter int unsigned ALERT_BIT = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_raw,
  input  logic       en_raw,
  input  logic       sel_raw,
  output logic [7:0] D,
  output logic       En,
  output logic       sel,
  output logic       en_rise,
  output logic       en_fall,
  output logic       clk_alert,
  output logic       alert_tick
);

  localparam int unsigned NumCh = 10;
  localparam int unsigned CntW  = $clog2(DB_CYCLES + 1);
  // Last count value of a qualification window; reaching it commits the change.
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    StStable0 = 2'd0,
    StWait1   = 2'd1,
    StStable1 = 2'd2,
    StWait0   = 2'd3
  } db_state_e;

  logic [NumCh-1:0] w_raw;
  logic [NumCh-1:0] r_sync1;
  logic [NumCh-1:0] r_sync2;
  logic [NumCh-1:0] w_out;

  assign w_raw = {sel_raw, en_raw, sw_raw};

  // Two-flop synchroniser for all channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    db_state_e       r_state;
    db_state_e       w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            r_out;
    logic            w_out_d;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= StStable0;
        r_cnt   <= '0;
        r_out   <= 1'b0;
      end else begin
        r_state <= w_state_d;
        r_cnt   <= w_cnt_d;
        r_out   <= w_out_d;
      end
    end

    // Next-state logic. Any disagreement during a wait state aborts back to the
    // previous stable state with the counter cleared, so no partial credit.
    always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      unique case (r_state)
        StStable0: begin
          if (r_sync2[i]) begin
            w_state_d = StWait1;
            w_cnt_d   = '0;
          end
        end
        StWait1: begin
          if (!r_sync2[i]) begin
            w_state_d = StStable0;
            w_cnt_d   = '0;
          end else if (r_cnt == CntLast) begin
            w_state_d = StStable1;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        StStable1: begin
          if (!r_sync2[i]) begin
            w_state_d = StWait0;
            w_cnt_d   = '0;
          end
        end
        StWait0: begin
          if (r_sync2[i]) begin
            w_state_d = StStable1;
            w_cnt_d   = '0;
          end else if (r_cnt == CntLast) begin
            w_state_d = StStable0;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        default: begin
          w_state_d = StStable0;
          w_cnt_d   = '0;
        end
      endcase
    end

    // Output logic: the debounced value holds its old level through the wait
    // states and is registered alongside the state.
    always_comb begin
      w_out_d = (w_state_d == StStable1) || (w_state_d == StWait0);
    end

    assign w_out[i] = r_out;
  end

  assign D   = w_out[7:0];
  assign En  = w_out[8];
  assign sel = w_out[9];

  // Enable edge pulses, one cycle after En changes.
  logic r_en_prev;
  logic r_en_rise;
  logic r_en_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_prev <= 1'b0;
      r_en_rise <= 1'b0;
      r_en_fall <= 1'b0;
    end else begin
      r_en_prev <= w_out[8];
      r_en_rise <= w_out[8] & ~r_en_prev;
      r_en_fall <= ~w_out[8] & r_en_prev;
    end
  end

  assign en_rise = r_en_rise;
  assign en_fall = r_en_fall;

  // Free-running divider.
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] w_div_d;
  logic             r_alert_tick;

  assign w_div_d = r_div + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_alert_tick <= 1'b0;
    end else begin
      r_div        <= w_div_d;
      // With a +1 counter, bit ALERT_BIT rises exactly when the low bits become
      // 1 followed by zeros, so the tick lines up with that counter value.
      r_alert_tick <= w_div_d[ALERT_BIT] & ~r_div[ALERT_BIT];
    end
  end

  assign clk_alert  = r_div[ALERT_BIT];
  assign alert_tick = r_alert_tick;

endmodule

// File: tb/tb_latch_input_conditioner.sv
module tb_latch_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_raw;
  logic       en_raw;
  logic       sel_raw;
  logic [7:0] D;
  logic       En;
  logic       sel;
  logic       en_rise;
  logic       en_fall;
  logic       clk_alert;
  logic       alert_tick;

  int n_tests = 0;
  int n_fail  = 0;

  latch_input_conditioner #(
    .DB_CYCLES(4),
    .CNT_W    (5),
    .ALERT_BIT(3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .en_raw    (en_raw),
    .sel_raw   (sel_raw),
    .D         (D),
    .En        (En),
    .sel       (sel),
    .en_rise   (en_rise),
    .en_fall   (en_fall),
    .clk_alert (clk_alert),
    .alert_tick(alert_tick)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    sw_raw  = 8'h00;
    en_raw  = 1'b0;
    sel_raw = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    logic [7:0]  exp_d;
    logic        exp_lvl;
    rst     = 1'b1;
    sw_raw  = 8'h00;
    en_raw  = 1'b0;
    sel_raw = 1'b0;
    step(); step(); step();
    obs = {D, En, sel, en_rise, en_fall};
    n_tests++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_values: got %h want 000", obs);
    end
    n_tests++;
    if ({clk_alert, alert_tick} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_divider: got %b want 00", {clk_alert, alert_tick});
    end
    // Raw inputs high while reset is held.
    sw_raw = 8'hFF; en_raw = 1'b1; sel_raw = 1'b1;
    step(); step(); step();
    obs = {D, En, sel, en_rise, en_fall};
    n_tests++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want 000", obs);
    end
    rst = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      exp_d   = (j >= 7) ? 8'hFF : 8'h00;
      exp_lvl = (j >= 7);
      n_tests++;
      if ({D, En, sel} !== {exp_d, exp_lvl, exp_lvl}) begin
        n_fail++;
        $display("FAIL release_qual j=%0d: got %h/%b/%b want %h/%b/%b",
                 j, D, En, sel, exp_d, exp_lvl, exp_lvl);
      end
      n_tests++;
      if ({en_rise, en_fall} !== {(j == 8), 1'b0}) begin
        n_fail++;
        $display("FAIL release_pulse j=%0d: got rise=%b fall=%b want rise=%b fall=0",
                 j, en_rise, en_fall, (j == 8));
      end
    end
    // Asynchronous assertion mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    obs = {D, En, sel, en_rise, en_fall};
    n_tests++;
    if (obs !== 12'h000 || clk_alert !== 1'b0 || alert_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %h alert=%b tick=%b want 000 0 0",
               obs, clk_alert, alert_tick);
    end
    step(); step();
    obs = {D, En, sel, en_rise, en_fall};
    n_tests++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset_hold: got %h want 000", obs);
    end
  endtask

  task automatic test_clean_step();
    logic [7:0] exp_d;
    do_reset();
    step(); step(); step();
    sw_raw = 8'hA5;
    for (int j = 0; j <= 7; j++) begin
      step();
      exp_d = (j >= 6) ? 8'hA5 : 8'h00;
      n_tests++;
      if (D !== exp_d) begin
        n_fail++;
        $display("FAIL clean_step j=%0d: got %h want %h", j, D, exp_d);
      end
      n_tests++;
      if ({En, en_rise, en_fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL clean_step_en j=%0d: got %b want 000", j, {En, en_rise, en_fall});
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int         rises;
    pat   = 5'b01101;  // bit j = en_raw at step j: 1,0,1,1,0
    rises = 0;
    for (int j = 0; j <= 15; j++) begin
      en_raw  = (j < 5) ? pat[j] : 1'b1;
      sel_raw = (j < 3);
      step();
      if (en_rise === 1'b1) rises++;
      n_tests++;
      if (En !== (j >= 11)) begin
        n_fail++;
        $display("FAIL bounce_en j=%0d: got %b want %b", j, En, (j >= 11));
      end
      n_tests++;
      if ({en_rise, en_fall} !== {(j == 12), 1'b0}) begin
        n_fail++;
        $display("FAIL bounce_pulse j=%0d: got rise=%b fall=%b want rise=%b fall=0",
                 j, en_rise, en_fall, (j == 12));
      end
      n_tests++;
      if (sel !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_sel j=%0d: got %b want 0", j, sel);
      end
    end
    n_tests++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_rise_count: got %0d want 1", rises);
    end
  endtask

  task automatic test_release();
    en_raw = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      step();
      n_tests++;
      if (En !== (j < 6)) begin
        n_fail++;
        $display("FAIL release_en j=%0d: got %b want %b", j, En, (j < 6));
      end
      n_tests++;
      if ({en_rise, en_fall} !== {1'b0, (j == 7)}) begin
        n_fail++;
        $display("FAIL release_fall j=%0d: got rise=%b fall=%b want rise=0 fall=%b",
                 j, en_rise, en_fall, (j == 7));
      end
    end
  endtask

  task automatic test_divider();
    logic exp_alert;
    logic exp_tick;
    do_reset();
    n_tests++;
    if ({clk_alert, alert_tick} !== 2'b00) begin
      n_fail++;
      $display("FAIL div_start: got %b want 00", {clk_alert, alert_tick});
    end
    // After n edges the 5-bit counter holds n mod 32.
    for (int n = 1; n <= 80; n++) begin
      step();
      exp_alert = ((n % 16) >= 8);
      exp_tick  = ((n % 16) == 8);
      n_tests++;
      if ({clk_alert, alert_tick} !== {exp_alert, exp_tick}) begin
        n_fail++;
        $display("FAIL divider n=%0d: got alert=%b tick=%b want alert=%b tick=%b",
                 n, clk_alert, alert_tick, exp_alert, exp_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); step();
    sw_raw = 8'h01;
    for (int j = 0; j <= 5; j++) begin
      step();
      n_tests++;
      if (D !== 8'h00) begin
        n_fail++;
        $display("FAIL mid_pre j=%0d: got %h want 00", j, D);
      end
    end
    rst = 1'b1;
    step(); step(); step();
    n_tests++;
    if (D !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_hold: got %h want 00", D);
    end
    rst = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      step();
      n_tests++;
      if (D !== ((j >= 7) ? 8'h01 : 8'h00)) begin
        n_fail++;
        $display("FAIL mid_requal j=%0d: got %h want %h", j, D, ((j >= 7) ? 8'h01 : 8'h00));
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    sw_raw  = 8'h00;
    en_raw  = 1'b0;
    sel_raw = 1'b0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_release();
    test_divider();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_input_conditioner.md
Name: latch_input_conditioner

Overview:
- Front-end stage that cleans the raw board inputs feeding the gate-level D-latch/LED-mux lab block.
- Double-flop synchronises and debounces the 8 data switches, the enable button and the select switch.
- Emits one-cycle edge pulses for the enable input.
- Generates the slow enable/alert strobe from a free-running divider, so the downstream latch consumes only clean, glitch-free signals.

Parameters:
- DB_CYCLES, 1000000, consecutive stable synchronised cycles required before a debounced output changes (10 ms at 100 MHz).
- CNT_W, 26, width of the free-running divider counter.
- ALERT_BIT, 23, divider bit driven out as clk_alert.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sw_raw  in  8  raw data switches
- en_raw  in  1  raw enable button
- sel_raw  in  1  raw select switch
- D  out  8  debounced data switches
- En  out  1  debounced enable
- sel  out  1  debounced select
- en_rise  out  1  one-cycle pulse when En goes 0->1
- en_fall  out  1  one-cycle pulse when En goes 1->0
- clk_alert  out  1  divider bit ALERT_BIT (slow square wave)
- alert_tick  out  1  one-cycle pulse on each 0->1 transition of clk_alert

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state is cleared immediately on rst=1 and held while asserted. Operation resumes on the first clk rising edge after release.
- Reset values:
  - all synchroniser flops 0
  - all debounce FSMs in S0
  - all debounce counters 0
  - D=8'h00, En=0, sel=0
  - en_rise=0, en_fall=0
  - divider=0, clk_alert=0, alert_tick=0
- Channels: 10 identical, independent channels (sw_raw[7:0], en_raw, sel_raw). Each has a 2-flop synchroniser, then a 4-state FSM with a counter of width clog2(DB_CYCLES+1).
- FSM states (out = registered debounced value):
  - S0 (out=0): sync=1 -> W1, counter cleared to 0. Else stay.
  - W1 (out=0): sync=0 -> S0, counter cleared. Else counter+1. If counter==DB_CYCLES-1 -> S1, out<=1.
  - S1 (out=1): sync=0 -> W0, counter cleared. Else stay.
  - W0 (out=1): sync=1 -> S1, counter cleared. Else counter+1. If counter==DB_CYCLES-1 -> S0, out<=0.
- Any bounce during W1/W0 aborts back to the previous stable state. No partial credit is kept; the counter restarts from 0 on the next change.
- Latency: raw level steady from clock edge k is sampled at edge k. The output changes at edge k+DB_CYCLES+2 (2 synchroniser cycles plus DB_CYCLES stable cycles). It never changes earlier.
- Pulses that are shorter than DB_CYCLES synchronised cycles never reach the outputs.
- en_rise / en_fall:
  - Registered: asserted for exactly one cycle, on the cycle after En changes.
  - Mutually exclusive.
  - Never asserted during or directly after reset.
- Divider:
  - CNT_W-bit counter, increments by 1 every clk and wraps from all-ones to 0 without any stall.
  - clk_alert = counter[ALERT_BIT], so its period is 2^(ALERT_BIT+1) cycles.
  - alert_tick = 1 for the single cycle in which counter[ALERT_BIT:0] == {1'b1, ALERT_BIT{1'b0}}.
- Simultaneous events: channels are fully independent. The divider is independent of all inputs.
- Reset mid-debounce: the channel returns to S0 with out=0, even if the raw input is still 1. It must then pass the full DB_CYCLES qualification again.
- DB_CYCLES must be >= 1. With DB_CYCLES=1, latency is 3 cycles.
- Outputs are registered; there is no combinational path from raw inputs to outputs.

Test Plan:
- Reset and hold: DB_CYCLES=4, ALERT_BIT=3, assert rst mid-cycle with all raw inputs=1 -> all outputs 0 immediately and while rst is held; after release, D=8'hFF exactly 6 cycles later; en_rise pulses once, one cycle after En rises.
- Clean step: DB_CYCLES=4, sw_raw 8'h00 -> 8'hA5 at edge k -> D==8'h00 through edge k+5 and D==8'hA5 from edge k+6; no en pulses.
- Bounce rejection: DB_CYCLES=4, en_raw toggles 1,0,1,1,0 on consecutive cycles then holds 1 -> En rises only 6 cycles after the final 0->1; exactly one en_rise; a 3-cycle glitch on sel_raw never changes sel.
- Release path: En stable 1, en_raw drops to 0 at edge k -> En=0 at edge k+6; en_fall high for exactly one cycle at edge k+7; en_rise stays 0.
- Divider: ALERT_BIT=3, CNT_W=5 -> clk_alert period 16 cycles (8 low, 8 high); alert_tick pulses at counter values 8 and 24; wrap 31->0 is seamless; period stays 16 after wrap.
- Reset mid-debounce: DB_CYCLES=4, sw_raw[0]=1, assert rst after 3 of 4 stable cycles -> D[0]=0; after release with input still 1, D[0] rises exactly 6 cycles later.
